// File: rtl/pkt_word_list_gen.sv
// Builds one complete word_list packet (header, checksums, counter words, padding) and
// streams it byte by byte into the pkt_comm input FIFO, stalling while the FIFO is full.
module pkt_word_list_gen #(
    parameter logic [7:0] PKT_VERSION = 8'h02,
    parameter logic [7:0] PKT_TYPE    = 8'h01,
    parameter int         MAX_KEY_LEN = 16,
    parameter bit         CHECKSUM_EN = 1'b1
) (
    input  logic        PKT_COMM_CLK,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic [4:0]  key_len,
    input  logic [15:0] pkt_id,
    output logic [7:0]  dout,
    output logic        wr_en,
    input  logic        full,
    output logic        busy,
    output logic        done,
    output logic [2:0]  dbg_state
);

    // Handshake: a byte is transferred in every cycle where wr_en=1; wr_en is only
    // raised while full=0, and while full=1 the byte and all pointers hold.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_HDR   = 3'd1,
        S_HCSUM = 3'd2,
        S_DATA  = 3'd3,
        S_PAD   = 3'd4,
        S_DCSUM = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic [4:0] MAX_KL = 5'(MAX_KEY_LEN);
    localparam logic [7:0] CH_A   = 8'h61;
    localparam logic [7:0] CH_Z   = 8'h7A;

    state_t      state_q;
    logic [23:0] cnt_q;
    logic [4:0]  pos_q;
    logic [4:0]  kl_q;
    logic [23:0] len_q;
    logic [15:0] id_q;
    logic [31:0] dsum_q;
    logic [7:0]  word_q [32];
    logic        busy_q;
    logic        done_q;

    logic [4:0]  kl_d;
    logic [5:0]  kl_plus1;
    logic [23:0] len_d;
    logic [7:0]  byte_d;
    logic [4:0]  cs_shift;
    logic [31:0] hdr_sum;
    logic [31:0] hcsum;
    logic [31:0] dcsum;
    logic [7:0]  word_inc [32];
    logic        carry;
    logic        last_data;

    // Request decode: clamp the key length and size the data section.
    always_comb begin
        kl_d     = (key_len > MAX_KL) ? MAX_KL : key_len;
        kl_plus1 = {1'b0, kl_d} + 6'd1;
        len_d    = {8'h00, word_count} * {18'h00000, kl_plus1};
    end

    // Checksums are the inverted 32-bit sum of little-endian words; header is static.
    always_comb begin
        cs_shift = {cnt_q[1:0], 3'b000};
        hdr_sum  = {len_q[15:0], PKT_TYPE, PKT_VERSION} + {id_q, 8'h00, len_q[23:16]};
        hcsum    = CHECKSUM_EN ? ~hdr_sum : 32'h0000_0000;
        dcsum    = CHECKSUM_EN ? ~dsum_q  : 32'h0000_0000;
    end

    // Byte currently offered to the FIFO.
    always_comb begin
        byte_d = 8'h00;
        case (state_q)
            S_HDR: begin
                case (cnt_q[2:0])
                    3'd0:    byte_d = PKT_VERSION;
                    3'd1:    byte_d = PKT_TYPE;
                    3'd2:    byte_d = len_q[7:0];
                    3'd3:    byte_d = len_q[15:8];
                    3'd4:    byte_d = len_q[23:16];
                    3'd5:    byte_d = 8'h00;
                    3'd6:    byte_d = id_q[7:0];
                    default: byte_d = id_q[15:8];
                endcase
            end
            S_HCSUM: byte_d = 8'(hcsum >> cs_shift);
            S_DATA:  byte_d = (pos_q < kl_q) ? word_q[pos_q] : 8'h00;
            S_DCSUM: byte_d = 8'(dcsum >> cs_shift);
            default: byte_d = 8'h00;
        endcase
    end

    // Next word: base-26 increment over 'a'..'z', rightmost char least significant.
    always_comb begin
        carry = 1'b1;
        for (int i = 0; i < 32; i++) begin
            word_inc[i] = word_q[i];
        end
        for (int i = MAX_KEY_LEN - 1; i >= 0; i--) begin
            if (carry && (5'(i) < kl_q)) begin
                if (word_q[i] == CH_Z) begin
                    word_inc[i] = CH_A;
                end else begin
                    word_inc[i] = word_q[i] + 8'd1;
                    carry       = 1'b0;
                end
            end
        end
    end

    assign last_data = (cnt_q == (len_q - 24'd1));

    always_ff @(posedge PKT_COMM_CLK) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pos_q   <= '0;
            kl_q    <= '0;
            len_q   <= '0;
            id_q    <= '0;
            dsum_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                word_q[i] <= CH_A;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= S_HDR;
                        kl_q    <= kl_d;
                        len_q   <= len_d;
                        id_q    <= pkt_id;
                        cnt_q   <= '0;
                        pos_q   <= '0;
                        dsum_q  <= '0;
                        busy_q  <= 1'b1;
                        for (int i = 0; i < 32; i++) begin
                            word_q[i] <= CH_A;
                        end
                    end
                end
                S_HDR: begin
                    if (!full) begin
                        if (cnt_q[2:0] == 3'd7) begin
                            state_q <= S_HCSUM;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                end
                S_HCSUM: begin
                    if (!full) begin
                        if (cnt_q[1:0] == 2'd3) begin
                            cnt_q   <= '0;
                            state_q <= (len_q == 24'd0) ? S_DCSUM : S_DATA;
                        end else begin
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                end
                S_DATA: begin
                    if (!full) begin
                        dsum_q <= dsum_q + (32'(byte_d) << cs_shift);
                        if (pos_q < kl_q) begin
                            pos_q <= pos_q + 5'd1;
                        end else begin
                            pos_q  <= '0;
                            word_q <= word_inc;
                        end
                        if (last_data && (len_q[1:0] == 2'd0)) begin
                            state_q <= S_DCSUM;
                            cnt_q   <= '0;
                        end else begin
                            // Keep counting into PAD so the byte lane stays aligned.
                            if (last_data) begin
                                state_q <= S_PAD;
                            end
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                end
                S_PAD: begin
                    if (!full) begin
                        if (cnt_q[1:0] == 2'd3) begin
                            state_q <= S_DCSUM;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                end
                S_DCSUM: begin
                    if (!full) begin
                        if (cnt_q[1:0] == 2'd3) begin
                            state_q <= S_DONE;
                            cnt_q   <= '0;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 24'd1;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign dout      = byte_d;
    assign wr_en     = busy_q & ~full;
    assign busy      = busy_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_pkt_word_list_gen.sv
// Scoreboard bench for pkt_word_list_gen: expected bytes are queued at stimulus time and a
// negedge monitor pops one per FIFO write; a second instance runs with checksums disabled.
module tb_pkt_word_list_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] word_count;
  logic [4:0]  key_len;
  logic [15:0] pkt_id;
  logic        full;
  logic [7:0]  dout;
  logic        wr_en;
  logic        busy;
  logic        done;
  logic [2:0]  dbg_state;
  logic [7:0]  dout_nc;
  logic        wr_en_nc;
  logic        busy_nc;
  logic        done_nc;
  logic [2:0]  dbg_state_nc;

  logic [7:0] exp_q[$];
  logic [7:0] exp_nc_q[$];
  int errors;
  int checks;
  int done_seen;

  pkt_word_list_gen #(.CHECKSUM_EN(1'b1)) u_dut (
    .PKT_COMM_CLK(clk), .rst(rst), .start(start), .word_count(word_count),
    .key_len(key_len), .pkt_id(pkt_id), .dout(dout), .wr_en(wr_en), .full(full),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  pkt_word_list_gen #(.CHECKSUM_EN(1'b0)) u_dut_nc (
    .PKT_COMM_CLK(clk), .rst(rst), .start(start), .word_count(word_count),
    .key_len(key_len), .pkt_id(pkt_id), .dout(dout_nc), .wr_en(wr_en_nc), .full(full),
    .busy(busy_nc), .done(done_nc), .dbg_state(dbg_state_nc)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // monitor
  always @(negedge clk) begin
    logic [7:0] e;
    if (wr_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write got=%02h exp=none", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL byte got=%02h exp=%02h", dout, e);
        end
      end
    end
    if (wr_en_nc) begin
      checks++;
      if (exp_nc_q.size() == 0) begin
        errors++;
        $display("FAIL nc_unexpected_write got=%02h exp=none", dout_nc);
      end else begin
        e = exp_nc_q.pop_front();
        if (dout_nc !== e) begin
          errors++;
          $display("FAIL nc_byte got=%02h exp=%02h", dout_nc, e);
        end
      end
    end
    if (full) begin
      checks++;
      if (wr_en !== 1'b0 || wr_en_nc !== 1'b0) begin
        errors++;
        $display("FAIL wr_en_while_full got=%0b/%0b exp=0", wr_en, wr_en_nc);
      end
    end
    if (done) done_seen++;
  end

  // driver / scoreboard tasks
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] b, input bit cs);
    exp_q.push_back(b);
    exp_nc_q.push_back(cs ? 8'h00 : b);
  endtask

  // Reference packet: words from base-26 digits of the word index, checksums by word grouping.
  task automatic push_model(input int wc, input int kraw, input logic [15:0] id);
    logic [7:0] h[$];
    logic [7:0] d[$];
    logic [7:0] c[16];
    logic [31:0] s;
    int kl;
    int len;
    int tmp;
    kl = (kraw > 16) ? 16 : kraw;
    len = wc * (kl + 1);
    h.push_back(8'h02); h.push_back(8'h01);
    h.push_back(8'(len)); h.push_back(8'(len >> 8)); h.push_back(8'(len >> 16));
    h.push_back(8'h00); h.push_back(id[7:0]); h.push_back(id[15:8]);
    for (int n = 0; n < wc; n++) begin
      tmp = n;
      for (int j = kl - 1; j >= 0; j--) begin
        c[j] = 8'd97 + 8'(tmp % 26);
        tmp = tmp / 26;
      end
      for (int j = 0; j < kl; j++) d.push_back(c[j]);
      d.push_back(8'h00);
    end
    while (d.size() % 4 != 0) d.push_back(8'h00);
    foreach (h[i]) push_exp(h[i], 1'b0);
    s = 32'h0;
    for (int k = 0; k < 2; k++) s = s + {h[4*k+3], h[4*k+2], h[4*k+1], h[4*k]};
    s = ~s;
    for (int k = 0; k < 4; k++) push_exp(8'(s >> (8*k)), 1'b1);
    foreach (d[i]) push_exp(d[i], 1'b0);
    s = 32'h0;
    for (int k = 0; k < d.size() / 4; k++) s = s + {d[4*k+3], d[4*k+2], d[4*k+1], d[4*k]};
    s = ~s;
    for (int k = 0; k < 4; k++) push_exp(8'(s >> (8*k)), 1'b1);
  endtask

  task automatic issue_start(input logic [15:0] wc, input logic [4:0] kl, input logic [15:0] id);
    @(posedge clk); #1;
    word_count = wc; key_len = kl; pkt_id = id; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_pkt(input string name, input logic [15:0] wc, input logic [4:0] kl,
                         input logic [15:0] id, input bit stall, input bit poke);
    int base;
    int cyc;
    bit seen;
    base = done_seen;
    issue_start(wc, kl, id);
    cyc = 1;
    seen = 1'b0;
    while (!seen && cyc < 3000) begin
      full = stall && ((cyc >= 9 && cyc <= 13) || (cyc >= 19 && cyc <= 23));
      if (poke && cyc == 5) begin
        start = 1'b1; word_count = 16'd7; key_len = 5'd3; pkt_id = 16'hDEAD;
      end
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        if (poke) start = 1'b1;
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
    end
    full = 1'b0;
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=no_done exp=done", name);
    end
    repeat (4) @(posedge clk);
    @(negedge clk);
    check({name, "_done_pulses"}, 32'(done_seen - base), 32'd1);
    check({name, "_bytes_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_nc_bytes_left"}, 32'(exp_nc_q.size()), 32'd0);
    check({name, "_busy_after"}, {31'd0, busy}, 32'd0);
    check({name, "_state_after"}, {29'd0, dbg_state}, 32'd0);
  endtask

  // stimulus
  logic [7:0] t1_vec [20] = '{8'h02, 8'h01, 8'h04, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00,
                              8'hFD, 8'hFE, 8'hF6, 8'hFF, 8'h61, 8'h00, 8'h62, 8'h00,
                              8'h9E, 8'hFF, 8'h9D, 8'hFF};
  logic [7:0] t4_vec [16] = '{8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12,
                              8'hFD, 8'hFE, 8'hCB, 8'hED, 8'hFF, 8'hFF, 8'hFF, 8'hFF};

  initial begin
    int base;
    errors = 0;
    checks = 0;
    done_seen = 0;
    rst = 1'b1;
    start = 1'b0;
    full = 1'b0;
    word_count = 16'd0;
    key_len = 5'd0;
    pkt_id = 16'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_dout", {24'd0, dout}, 32'd0);
    check("rst_wr_en", {31'd0, wr_en}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // T1: two one-char words, hand-computed stream
    for (int i = 0; i < 20; i++) push_exp(t1_vec[i], (i >= 8 && i < 12) || i >= 16);
    run_pkt("t1", 16'd2, 5'd1, 16'h0005, 1'b0, 1'b0);

    // T2: two-char counter across the 'z' carry
    push_model(28, 2, 16'hBEEF);
    run_pkt("t2", 16'd28, 5'd2, 16'hBEEF, 1'b0, 1'b0);

    // T3: T1 with FIFO-full stalls in HCSUM and DATA
    for (int i = 0; i < 20; i++) push_exp(t1_vec[i], (i >= 8 && i < 12) || i >= 16);
    run_pkt("t3", 16'd2, 5'd1, 16'h0005, 1'b1, 1'b0);

    // T4: empty data section
    for (int i = 0; i < 16; i++) push_exp(t4_vec[i], i >= 8);
    run_pkt("t4", 16'd0, 5'd3, 16'h1234, 1'b0, 1'b0);

    // T5: key_len clamped to 16, 3 PAD bytes
    push_model(1, 20, 16'h00A5);
    run_pkt("t5", 16'd1, 5'd20, 16'h00A5, 1'b0, 1'b0);

    // kl=0: bare terminators
    push_model(5, 0, 16'h0102);
    run_pkt("kl0", 16'd5, 5'd0, 16'h0102, 1'b0, 1'b0);

    // kl=1 past 'z': leftmost carry wraps to 'a'; start pokes while busy and in DONE
    push_model(28, 1, 16'h4242);
    run_pkt("wrap", 16'd28, 5'd1, 16'h4242, 1'b0, 1'b1);

    // T6: reset during DATA, then a fresh packet
    push_model(3, 2, 16'h0777);
    base = done_seen;
    issue_start(16'd3, 5'd2, 16'h0777);
    repeat (14) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6_busy_after_rst", {31'd0, busy}, 32'd0);
    check("t6_wr_en_after_rst", {31'd0, wr_en}, 32'd0);
    check("t6_state_after_rst", {29'd0, dbg_state}, 32'd0);
    check("t6_no_done", 32'(done_seen - base), 32'd0);
    exp_q.delete();
    exp_nc_q.delete();
    push_model(3, 2, 16'h0778);
    run_pkt("t6", 16'd3, 5'd2, 16'h0778, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
